// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Optional illegal-opcode trap is enabled by defining ALU_ARBITER_ILLEGAL_OP_EN.
package alu_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int                  ALU_OP_W       = 3;
    localparam logic [ALU_OP_W-1:0] ALU_OP_ILLEGAL = 3'b111;
    localparam int                  ALU_N_DEFAULT  = 16;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of request, ALU and response signals around the arbiter.
// slave = the arbiter itself; master = everything around it (clients, ALU, response sink).
interface alu_arbiter_if
    import alu_arbiter_pkg::*;
#(
    parameter int N = ALU_N_DEFAULT
) ();

    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [N-1:0]        req0_a;
    logic [N-1:0]        req0_b;
    logic [ALU_OP_W-1:0] req0_op;
    logic [N-1:0]        req1_a;
    logic [N-1:0]        req1_b;
    logic [ALU_OP_W-1:0] req1_op;

    logic [N-1:0]        alu_a;
    logic [N-1:0]        alu_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic [N-1:0]        alu_y;
    logic                alu_zero;

    logic                rsp_valid;
    logic                rsp_ready;
    logic                rsp_id;
    logic [N-1:0]        rsp_y;
    logic                rsp_zero;
    logic                rsp_err;

    modport slave (
        input  req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
        input  alu_y, alu_zero, rsp_ready,
        output req_ready, alu_a, alu_b, alu_op,
        output rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_err
    );

    modport master (
        output req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
        output alu_y, alu_zero, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_op,
        input  rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_err
    );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin picker: combinational only, the "last served" pointer lives in the parent.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the block can infer a latch.
        gnt_id = 1'b0;
        gnt    = 2'b00;
        case (req)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = ~last;
            default: gnt_id = 1'b0;
        endcase
        if (|req) begin
            gnt = gnt_id ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one pipelined ALU between two valid/ready requesters with a single response channel.
// Optional feature: ALU_ARBITER_ILLEGAL_OP_EN traps opcode 3'b111 without touching the ALU.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int N       = ALU_N_DEFAULT,
    parameter int ALU_LAT = 1
) (
    input logic          clk,
    input logic          rst_n,
    alu_arbiter_if.slave bus
);

    localparam int               CNT_W    = $clog2(ALU_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LAT);

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic                last;
    logic [1:0]          gnt;
    logic                gnt_id;
    logic [N-1:0]        sel_a;
    logic [N-1:0]        sel_b;
    logic [ALU_OP_W-1:0] sel_op;
    logic                sel_illegal;
    logic                accept;
    logic                capture;
    logic                rsp_done;
    logic [1:0]          req_ready_c;
    logic [N-1:0]        alu_a_q;
    logic [N-1:0]        alu_b_q;
    logic [ALU_OP_W-1:0] alu_op_q;
    logic                rsp_id_q;
    logic [N-1:0]        rsp_y_q;
    logic                rsp_zero_q;

    rr_arb2 u_rr_arb2 (
        .req    (bus.req_valid),
        .last   (last),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign sel_a  = gnt_id ? bus.req1_a  : bus.req0_a;
    assign sel_b  = gnt_id ? bus.req1_b  : bus.req0_b;
    assign sel_op = gnt_id ? bus.req1_op : bus.req0_op;

`ifdef ALU_ARBITER_ILLEGAL_OP_EN
    assign sel_illegal = (sel_op == ALU_OP_ILLEGAL);
`else
    assign sel_illegal = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registers use non-blocking assignments so all of them sample pre-edge values.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The ALU result is valid ALU_LAT edges after its inputs settle, so it is sampled one edge later.
    always_comb begin
        state_nxt   = state;
        req_ready_c = 2'b00;
        accept      = 1'b0;
        capture     = 1'b0;
        rsp_done    = 1'b0;
        case (state)
            IDLE: begin
                if (|gnt) begin
                    req_ready_c = gnt;
                    accept      = 1'b1;
                    state_nxt   = sel_illegal ? RESP : EXEC;
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            last       <= 1'b1;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            rsp_id_q   <= 1'b0;
            rsp_y_q    <= '0;
            rsp_zero_q <= 1'b0;
        end else begin
            if (accept) begin
                rsp_id_q <= gnt_id;
                if (sel_illegal) begin
                    rsp_y_q    <= '0;
                    rsp_zero_q <= 1'b0;
                end else begin
                    alu_a_q  <= sel_a;
                    alu_b_q  <= sel_b;
                    alu_op_q <= sel_op;
                    cnt      <= CNT_LOAD;
                end
            end else if (state == EXEC && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (capture) begin
                rsp_y_q    <= bus.alu_y;
                rsp_zero_q <= bus.alu_zero;
            end
            if (rsp_done) begin
                last <= rsp_id_q;
            end
        end
    end

`ifdef ALU_ARBITER_ILLEGAL_OP_EN
    logic rsp_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err_q <= 1'b0;
        end else if (accept) begin
            rsp_err_q <= sel_illegal;
        end
    end

    assign bus.rsp_err = rsp_err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.req_ready = req_ready_c;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, corner sequences, random run vs model.
// Override parameter ALU_LAT to build with a longer ALU pipeline; ALU_ARBITER_ILLEGAL_OP_EN is honoured.
module tb_alu_arbiter #(
  parameter int ALU_LAT = 1
);
    import alu_arbiter_pkg::*;

    localparam int N = 16;
`ifdef ALU_ARBITER_ILLEGAL_OP_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    typedef struct {
        bit          id;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic [15:0] y;
        bit          zero;
    } vec_t;

    typedef struct {
        bit          id;
        logic [15:0] y;
        bit          zero;
        bit          err;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_arbiter_if #(.N(N)) bus ();

    alu_arbiter #(.N(N), .ALU_LAT(ALU_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // ALU stub: y = a + b + op through ALU_LAT register stages
    logic [N-1:0] pipe_y [ALU_LAT];
    always @(posedge clk) begin
        pipe_y[0] <= bus.alu_a + bus.alu_b + N'(bus.alu_op);
        for (int i = 1; i < ALU_LAT; i++) pipe_y[i] <= pipe_y[i-1];
    end
    assign bus.alu_y    = pipe_y[ALU_LAT-1];
    assign bus.alu_zero = (bus.alu_y == '0);

    int          n_vec = 0;
    int          n_err = 0;
    logic [2:0]  prev_op;
    bit          mon_en = 1'b0;
    bit          m_busy;
    bit          m_last;
    exp_t        exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_y(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] op);
        int unsigned s;
        if (ILL_EN && op == ALU_OP_ILLEGAL) return 16'd0;
        s = 32'(a) + 32'(b) + 32'(op);
        return 16'(s % 65536);
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        prev_op = 3'd0;
    endtask

    task automatic release_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic wait_rsp(input string name);
        int c = 0;
        while (!bus.rsp_valid && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        check(name, 32'(bus.rsp_valid), 32'd1);
    endtask

    task automatic scramble();
        bus.req0_a  = 16'($urandom);
        bus.req0_b  = 16'($urandom);
        bus.req0_op = 3'($urandom);
        bus.req1_a  = 16'($urandom);
        bus.req1_b  = 16'($urandom);
        bus.req1_op = 3'($urandom);
    endtask

    task automatic run_single(input vec_t v);
        int lat;
        bit ill;
        ill = ILL_EN && (v.op == ALU_OP_ILLEGAL);
        @(posedge clk); #1;
        scramble();
        if (v.id) begin
            bus.req1_a = v.a; bus.req1_b = v.b; bus.req1_op = v.op;
        end else begin
            bus.req0_a = v.a; bus.req0_b = v.b; bus.req0_op = v.op;
        end
        bus.req_valid = v.id ? 2'b10 : 2'b01;
        @(negedge clk);
        check("single_req_ready", 32'(bus.req_ready), v.id ? 32'd2 : 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        scramble();
        lat = 0;
        while (!bus.rsp_valid && lat < 64) begin
            check("single_ready_low", 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        check("single_latency", 32'(lat), ill ? 32'd0 : 32'(ALU_LAT + 1));
        check("single_rsp_id", 32'(bus.rsp_id), 32'(v.id));
        check("single_rsp_y", 32'(bus.rsp_y), 32'(v.y));
        check("single_rsp_zero", 32'(bus.rsp_zero), 32'(v.zero));
        check("single_rsp_err", 32'(bus.rsp_err), 32'(ill));
        check("single_alu_op", 32'(bus.alu_op), ill ? 32'(prev_op) : 32'(v.op));
        if (!ill) prev_op = v.op;
        release_rsp();
        check("single_rsp_clear", 32'(bus.rsp_valid), 32'd0);
    endtask

    task automatic contention();
        int got = 0;
        int cyc = 0;
        do_reset();
        @(posedge clk); #1;
        bus.req0_a = 16'd1;      bus.req0_b = 16'd1; bus.req0_op = 3'd0;
        bus.req1_a = 16'hFFFF;   bus.req1_b = 16'd1; bus.req1_op = 3'd0;
        bus.req_valid = 2'b11;
        bus.rsp_ready = 1'b1;
        while (got < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.rsp_valid && bus.rsp_ready) begin
                check("cont_id", 32'(bus.rsp_id), 32'(got % 2));
                check("cont_y", 32'(bus.rsp_y), (got % 2) ? 32'd0 : 32'd2);
                check("cont_zero", 32'(bus.rsp_zero), 32'(got % 2));
                got++;
            end
        end
        check("cont_count", 32'(got), 32'd4);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic backpressure();
        @(posedge clk); #1;
        bus.req0_a = 16'd7; bus.req0_b = 16'd9; bus.req0_op = 3'd1;
        bus.req_valid = 2'b01;
        wait_rsp("bp_first_rsp");
        bus.req1_a = 16'd2; bus.req1_b = 16'd2; bus.req1_op = 3'd0;
        bus.req_valid = 2'b11;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid_held", 32'(bus.rsp_valid), 32'd1);
            check("bp_y_held", 32'(bus.rsp_y), 32'd17);
            check("bp_id_held", 32'(bus.rsp_id), 32'd0);
            check("bp_ready_blocked", 32'(bus.req_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_no_grant_on_rsp", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_next_grant", 32'(bus.req_ready), 32'd2);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        wait_rsp("bp_second_rsp");
        check("bp_second_id", 32'(bus.rsp_id), 32'd1);
        check("bp_second_y", 32'(bus.rsp_y), 32'd4);
        release_rsp();
    endtask

    task automatic reset_mid_exec();
        @(posedge clk); #1;
        bus.req1_a = 16'd5; bus.req1_b = 16'd6; bus.req1_op = 3'd3;
        bus.req_valid = 2'b10;
        @(negedge clk);
        check("rst_pre_grant", 32'(bus.req_ready), 32'd2);
        @(posedge clk); #1;
        check("rst_pre_alu_a", 32'(bus.alu_a), 32'd5);
        rst_n = 1'b0;
        bus.req_valid = 2'b00;
        #1;
        check("rst_alu_a", 32'(bus.alu_a), 32'd0);
        check("rst_alu_b", 32'(bus.alu_b), 32'd0);
        check("rst_alu_op", 32'(bus.alu_op), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_y", 32'(bus.rsp_y), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        prev_op = 3'd0;
        repeat (ALU_LAT + 3) begin
            @(negedge clk);
            check("rst_no_stale_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
        bus.req0_a = 16'd20; bus.req0_b = 16'd22; bus.req0_op = 3'd0;
        bus.req_valid = 2'b11;
        @(negedge clk);
        check("rst_favours_req0", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        wait_rsp("rst_post_rsp");
        check("rst_post_id", 32'(bus.rsp_id), 32'd0);
        check("rst_post_y", 32'(bus.rsp_y), 32'd42);
        release_rsp();
    endtask

    // Transaction-level model: one op in flight, winner is the requester not served last.
    always @(negedge clk) begin
        bit          was_busy;
        logic [1:0]  exp_g;
        logic [2:0]  gop;
        exp_t        e;
        if (mon_en) begin
            was_busy = m_busy;
            if (was_busy) begin
                check("rand_ready_busy", 32'(bus.req_ready), 32'd0);
            end else begin
                case (bus.req_valid)
                    2'b01:   exp_g = 2'b01;
                    2'b10:   exp_g = 2'b10;
                    2'b11:   exp_g = m_last ? 2'b01 : 2'b10;
                    default: exp_g = 2'b00;
                endcase
                check("rand_grant", 32'(bus.req_ready), 32'(exp_g));
                check("rand_rsp_idle", 32'(bus.rsp_valid), 32'd0);
                if (exp_g != 2'b00) begin
                    e.id   = exp_g[1];
                    gop    = e.id ? bus.req1_op : bus.req0_op;
                    e.err  = ILL_EN && (gop == ALU_OP_ILLEGAL);
                    e.y    = e.id ? ref_y(bus.req1_a, bus.req1_b, gop)
                                  : ref_y(bus.req0_a, bus.req0_b, gop);
                    e.zero = !e.err && (e.y == 16'd0);
                    exp_q.push_back(e);
                    m_busy = 1'b1;
                end
            end
            if (was_busy && bus.rsp_valid && bus.rsp_ready) begin
                e = exp_q.pop_front();
                check("rand_rsp_id", 32'(bus.rsp_id), 32'(e.id));
                check("rand_rsp_y", 32'(bus.rsp_y), 32'(e.y));
                check("rand_rsp_zero", 32'(bus.rsp_zero), 32'(e.zero));
                check("rand_rsp_err", 32'(bus.rsp_err), 32'(e.err));
                m_last = e.id;
                m_busy = 1'b0;
            end
        end
    end

    task automatic random_phase();
        int cyc = 0;
        do_reset();
        m_last = 1'b1;
        m_busy = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
        repeat (1500) begin
            @(posedge clk); #1;
            bus.req_valid = 2'($urandom);
            scramble();
            bus.rsp_ready = ($urandom_range(3) != 0);
        end
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;
        while (m_busy && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("rand_drain", 32'(m_busy), 32'd0);
        mon_en = 1'b0;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        vec_t vecs[7];
        vecs[0] = '{1'b0, 16'd3,     16'd5,     3'd2, 16'd10,   1'b0};
        vecs[1] = '{1'b1, 16'hFFFF,  16'd1,     3'd0, 16'd0,    1'b1};
        vecs[2] = '{1'b0, 16'h8000,  16'h7FFF,  3'd1, 16'd0,    1'b1};
        vecs[3] = '{1'b1, 16'd100,   16'd200,   3'd4, 16'd304,  1'b0};
        vecs[4] = '{1'b0, 16'd0,     16'd0,     3'd0, 16'd0,    1'b1};
        vecs[5] = '{1'b1, 16'h1234,  16'h0001,  3'd7, ILL_EN ? 16'h0000 : 16'h123C, 1'b0};
        vecs[6] = '{1'b0, 16'hFFFF,  16'hFFFF,  3'd3, 16'h0001, 1'b0};

        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b0;
        scramble();
        do_reset();
        #1;
        check("reset_alu_a", 32'(bus.alu_a), 32'd0);
        check("reset_alu_b", 32'(bus.alu_b), 32'd0);
        check("reset_alu_op", 32'(bus.alu_op), 32'd0);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("reset_rsp_y", 32'(bus.rsp_y), 32'd0);
        check("reset_rsp_zero", 32'(bus.rsp_zero), 32'd0);
        check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("reset_req_ready", 32'(bus.req_ready), 32'd0);

        for (int i = 0; i < 7; i++) run_single(vecs[i]);
        contention();
        backpressure();
        reset_mid_exec();
        random_phase();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
